register_file: RTL and testbench

- 32 x 32-bit RISC-V integer register file for the single-cycle datapath.
- Sits directly upstream of the ALU. Read port 1 drives ALU operand A; read port 2 drives operand B through the immediate mux.
- Write port receives the write-back value (ALU result, load data or PC+4) at the end of each instruction's cycle.
- Register x0 is hardwired to zero. The stack pointer (x2) and global pointer (x3) have programmable reset values.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/regfile_read_port.sv | 19 +
 rtl/register_file.sv | 43 ++++
 tb/tb_register_file.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I datapath constants (register indices, widths, pointer reset values).
package riscv_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP = 5'd2;
    localparam logic [4:0] REG_GP = 5'd3;
    localparam logic [31:0] SP_RESET_DEF = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_RESET_DEF = 32'h1000_8000;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with x0 forced to zero and optional write bypass.
module regfile_read_port
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BYPASS_EN = 0
)(
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_regs [2**ADDR_WIDTH],
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic w_bypass;
    assign w_bypass = (BYPASS_EN != 0) && i_wr_en && (i_wr_addr == i_addr);
    assign o_data = (i_addr == ADDR_WIDTH'(REG_ZERO)) ? '0 : w_bypass ? i_wr_data : i_regs[i_addr];
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 RISC-V integer register file, two combinational reads, one write,
// x0 hardwired to zero, programmable sp/gp reset values.
module register_file
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] SP_RESET = SP_RESET_DEF,
    parameter logic [DATA_WIDTH-1:0] GP_RESET = GP_RESET_DEF,
    parameter int BYPASS_EN = 0
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Reg_Write_i,
    input  logic [ADDR_WIDTH-1:0] Write_Register_i,
    input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
    input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    output logic [DATA_WIDTH-1:0] Read_Data_1_o,
    output logic [DATA_WIDTH-1:0] Read_Data_2_o
);
    localparam int NREG = 2**ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] r_regs [NREG];
    logic                  w_wr_en;
    // Gating with reset keeps bypass from exposing a write that reset is discarding.
    assign w_wr_en = reset && Reg_Write_i && (Write_Register_i != ADDR_WIDTH'(REG_ZERO));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= (i == int'(REG_SP)) ? SP_RESET : (i == int'(REG_GP)) ? GP_RESET : '0;
        end else if (w_wr_en) begin
            r_regs[Write_Register_i] <= Write_Data_i;
        end
    end
    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BYPASS_EN(BYPASS_EN)) u_rp1 (
        .i_addr(Read_Register_1_i), .i_regs(r_regs), .i_wr_en(w_wr_en),
        .i_wr_addr(Write_Register_i), .i_wr_data(Write_Data_i), .o_data(Read_Data_1_o)
    );
    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BYPASS_EN(BYPASS_EN)) u_rp2 (
        .i_addr(Read_Register_2_i), .i_regs(r_regs), .i_wr_en(w_wr_en),
        .i_wr_addr(Write_Register_i), .i_wr_data(Write_Data_i), .o_data(Read_Data_2_o)
    );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: drives a no-bypass and a bypass register file with shared stimulus and
// checks both against an array model every cycle plus literal directed expectations.
module tb_register_file;
    localparam logic [31:0] SP = 32'h7FFF_EFFC;
    localparam logic [31:0] GP = 32'h1000_8000;
    logic        clk = 0;
    logic        reset;
    logic        we;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] wd;
    logic [31:0] a0, b0, a1, b1;
    logic [31:0] m [32];
    int          n_tests = 0;
    int          n_fail = 0;

    register_file #(.BYPASS_EN(0)) u_nb (
        .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(rd),
        .Read_Register_1_i(rs1), .Read_Register_2_i(rs2), .Write_Data_i(wd),
        .Read_Data_1_o(a0), .Read_Data_2_o(b0)
    );
    register_file #(.BYPASS_EN(1)) u_by (
        .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(rd),
        .Read_Register_1_i(rs1), .Read_Register_2_i(rs2), .Write_Data_i(wd),
        .Read_Data_1_o(a1), .Read_Data_2_o(b1)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] <= (i == 2) ? SP : (i == 3) ? GP : 32'h0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else if (we && rd != 5'd0) m[rd] <= wd;
    end

    function automatic logic [31:0] expv(input logic [4:0] rs, input bit byp);
        if (rs == 5'd0) return 32'h0;
        if (byp && reset && we && rd == rs) return wd;
        return m[rs];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("nb_port1", a0, expv(rs1, 0));
        chk("nb_port2", b0, expv(rs2, 0));
        chk("by_port1", a1, expv(rs1, 1));
        chk("by_port2", b1, expv(rs2, 1));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1; we = 0; rd = 0; rs1 = 0; rs2 = 1; wd = 0;
        model_reset();
        #1 reset = 0;
        #1 chk("rst_x0", a0, 32'h0);
        chk("rst_x1", b0, 32'h0);
        rs1 = 2; rs2 = 3;
        #1 chk("rst_sp", a0, SP);
        chk("rst_gp", b0, GP);
        chk("rst_gp_byp", b1, GP);
        rs2 = 31;
        #1 chk("rst_x31", b0, 32'h0);
        tick();
        reset = 1;
        tick();
        chk("idle_sp", a0, SP);
        we = 1; rd = 5; wd = 32'hDEAD_BEEF;
        tick();
        rd = 31; wd = 32'h8000_0000;
        tick();
        we = 0; rs1 = 5; rs2 = 31;
        #1 chk("wr_x5", a0, 32'hDEAD_BEEF);
        chk("wr_x31", b0, 32'h8000_0000);
        rd = 5; wd = 32'h1;
        tick();
        chk("nowe_x5", a0, 32'hDEAD_BEEF);
        we = 1; rd = 0; wd = 32'hFFFF_FFFF; rs1 = 0; rs2 = 0;
        #1 chk("x0_same_nb", a0, 32'h0);
        chk("x0_same_by", a1, 32'h0);
        tick();
        we = 0;
        #1 chk("x0_next_nb", a0, 32'h0);
        chk("x0_next_by", b1, 32'h0);
        we = 1; rd = 7; wd = 32'h11;
        tick();
        wd = 32'h22; rs1 = 7; rs2 = 7;
        #1 chk("rbw_nb1", a0, 32'h11);
        chk("rbw_nb2", b0, 32'h11);
        chk("byp_1", a1, 32'h22);
        chk("byp_2", b1, 32'h22);
        tick();
        we = 0;
        #1 chk("after_nb1", a0, 32'h22);
        chk("after_nb2", b0, 32'h22);
        chk("after_by1", a1, 32'h22);
        we = 1; rd = 10; wd = 32'h1234;
        tick();
        rd = 2; wd = 32'h0;
        tick();
        we = 0; rs1 = 10; rs2 = 2;
        #1 chk("pre_x10", a0, 32'h1234);
        chk("pre_sp", b0, 32'h0);
        #1 reset = 0;
        #1 chk("async_x10", a0, 32'h0);
        chk("async_sp", b0, SP);
        chk("async_sp_by", b1, SP);
        we = 1; rd = 10; wd = 32'h55;
        tick();
        chk("rst_wr_nb", a0, 32'h0);
        chk("rst_wr_by", a1, 32'h0);
        we = 0;
        reset = 1;
        tick();
        for (int c = 0; c < 10000; c++) begin
            we = 1'($urandom);
            rd = 5'($urandom);
            wd = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            tick();
        end
        we = 0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
